// File: rtl/bin2bcd_seq_disp.sv
// Sequential shift-add-3 binary-to-BCD converter with registered active-low 7-segment codes.
// One bit is shifted per cycle; results, overflow and segment codes update together on done.
module bin2bcd_seq_disp #(
  parameter int IN_W     = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [DIGITS*7-1:0]   seg_out
);

  localparam int INT_D = (IN_W * 302) / 1000 + 1;
  localparam int PAD_D = (INT_D > DIGITS) ? INT_D : DIGITS;
  localparam int PAD_W = PAD_D * 4;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;
  logic [INT_D*4-1:0]    acc;
  logic [INT_D*4-1:0]    acc_adj;
  logic [IN_W-1:0]       shreg;
  logic [PAD_W-1:0]      acc_pad;
  logic                  ovf_c;
  logic [DIGITS*4-1:0]   bcd_c;
  logic [DIGITS*7-1:0]   seg_c;
  logic                  higher_zero;
  logic [3:0]            dig;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction keeps every digit within 0..9 after the following doubling.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < INT_D; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  // Zero-padding lets DIGITS exceed the internal digit count without out-of-range slices.
  assign acc_pad = PAD_W'(acc);
  assign bcd_c   = acc_pad[DIGITS*4-1:0];

  always_comb begin
    ovf_c = 1'b0;
    for (int k = 0; k < PAD_D; k++) begin
      if (k >= DIGITS && acc_pad[4*k +: 4] != 4'd0) ovf_c = 1'b1;
    end
  end

  always_comb begin
    seg_c       = '1;
    higher_zero = 1'b1;
    dig         = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig         = acc_pad[4*k +: 4];
      higher_zero = higher_zero && (dig == 4'd0);
      if (ovf_c)
        seg_c[7*k +: 7] = SEG_DASH;
      else if (BLANK_LZ != 0 && k > 0 && higher_zero)
        seg_c[7*k +: 7] = SEG_BLANK;
      else
        seg_c[7*k +: 7] = seg_code(dig);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      acc     <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
      seg_out <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= bin_in;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc   <= {acc_adj[INT_D*4-2:0], shreg[IN_W-1]};
          shreg <= {shreg[IN_W-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == CNT_W'(IN_W - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_out <= bcd_c;
          ovf     <= ovf_c;
          seg_out <= seg_c;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_disp.sv
// Directed bench for bin2bcd_seq_disp: default build, no-blanking build and a 3-digit build
// share one stimulus stream; expectations are hand-computed constants.
module tb_bin2bcd_seq_disp;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  bin_in;

  logic        busy0, done0, ovf0;
  logic [15:0] bcd0;
  logic [27:0] seg0;
  logic        busy1, done1, ovf1;
  logic [15:0] bcd1;
  logic [27:0] seg1;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd2;
  logic [20:0] seg2;

  int errors;
  int checks;

  logic [15:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_disp #(.IN_W(10), .DIGITS(4), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd_out(bcd0), .seg_out(seg0)
  );

  bin2bcd_seq_disp #(.IN_W(10), .DIGITS(4), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd_out(bcd1), .seg_out(seg1)
  );

  bin2bcd_seq_disp #(.IN_W(10), .DIGITS(3), .BLANK_LZ(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd_out(bcd2), .seg_out(seg2)
  );

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle start pulse; waits for done and checks busy length and latency.
  task automatic convert(input logic [9:0] v);
    int busy_cnt;
    int lat;
    bit got;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~v;
    busy_cnt = 0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (busy0) busy_cnt++;
      if (done0) begin
        got = 1'b1;
        lat = i;
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(lat), 32'd12);
    chk("busy_cycles", 32'(busy_cnt), 32'd11);
    @(negedge clk);
    chk("done_one_cycle", 32'(done0), 32'd0);
  endtask

  task automatic sample_held(inout int n_done, inout logic prev_done);
    logic [15:0] e;
    if (done0) begin
      n_done++;
      chk("held_done_gap", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("held_extra_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("held_bcd", 32'(bcd0), 32'(e));
      end
    end
    prev_done = done0;
  endtask

  initial begin
    int   n_done;
    logic prev_done;
    int   mid_done;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_bcd", 32'(bcd0), 32'h0);
    chk("rst_seg", 32'(seg0), 32'h0FFF_FFFF);
    rst = 1'b0;

    // 2: zero
    convert(10'd0);
    chk("zero_bcd", 32'(bcd0), 32'h0);
    chk("zero_seg_blank", 32'(seg0), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}));
    chk("zero_seg_noblank", 32'(seg1), 32'({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}));
    chk("zero_ovf", 32'(ovf0), 32'd0);

    // 3: full-scale input
    convert(10'd1023);
    chk("max_bcd", 32'(bcd0), 32'h1023);
    chk("max_seg", 32'(seg0), 32'({7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110}));
    chk("max_ovf", 32'(ovf0), 32'd0);
    chk("max3_ovf", 32'(ovf2), 32'd1);
    chk("max3_bcd", 32'(bcd2), 32'h023);
    chk("max3_seg", 32'(seg2), 32'({7'b1111110, 7'b1111110, 7'b1111110}));

    // 4: leading-zero blanking on/off
    convert(10'd7);
    chk("seven_bcd", 32'(bcd0), 32'h0007);
    chk("seven_seg_blank", 32'(seg0), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}));
    chk("seven_seg_noblank", 32'(seg1), 32'({7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}));

    // 5: overflow boundary of the 3-digit build
    convert(10'd1000);
    chk("k_ovf3", 32'(ovf2), 32'd1);
    chk("k_bcd3", 32'(bcd2), 32'h000);
    chk("k_seg3", 32'(seg2), 32'({7'b1111110, 7'b1111110, 7'b1111110}));
    chk("k_bcd4", 32'(bcd0), 32'h1000);
    chk("k_seg4", 32'(seg0), 32'({7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}));
    convert(10'd999);
    chk("n999_ovf3", 32'(ovf2), 32'd0);
    chk("n999_bcd3", 32'(bcd2), 32'h999);
    chk("n999_seg3", 32'(seg2), 32'({7'b0000100, 7'b0000100, 7'b0000100}));

    // 6a: start held 30 cycles with bin_in changing every cycle
    exp_q = {16'h0005, 16'h0449, 16'h0893};
    n_done = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sample_held(n_done, prev_done);
      bin_in = 10'((i * 37 + 5) % 1024);
      start  = 1'b1;
    end
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      sample_held(n_done, prev_done);
      if (j == 0) start = 1'b0;
    end
    chk("held_conversions", 32'(n_done), 32'd3);

    // 6b: reset in the middle of a conversion
    @(negedge clk);
    bin_in = 10'd321;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_ovf", 32'(ovf0), 32'd0);
    chk("abort_bcd", 32'(bcd0), 32'h0);
    chk("abort_seg", 32'(seg0), 32'h0FFF_FFFF);
    mid_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done0) mid_done++;
    end
    chk("abort_no_done", 32'(mid_done), 32'd0);
    convert(10'd512);
    chk("after_abort_bcd", 32'(bcd0), 32'h0512);
    chk("after_abort_seg", 32'(seg0), 32'({7'b1111111, 7'b0100100, 7'b1001111, 7'b0010010}));

    do_reset();
    @(negedge clk);
    chk("final_rst_bcd", 32'(bcd0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
